fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Parametrised program-counter sequencer for the processor fetch path. It generalises the flat PC and the fixed "done at 128" compare into one block with several added features:
- req/done start handshake
- conditional relative and absolute jumps qualified by registered ALU flags
- a call/return stack of configurable depth
- a stall input

It sits between the control decoder/flag registers and the instruction ROM, and drives `prog_ctr` directly.

## Interface
- `D`, 12 — program counter width in bits.
- `S`, 4 — return-stack depth in entries (≥1).
- `DONE_ADDR`, 128 — PC value that terminates a program.

- `clk` in 1 — single clock, all state on rising edge.
- `reset` in 1 — asynchronous, active-high; clears all state immediately.
- `req` in 1 — start request; level-sensitive handshake with `done`.
- `stall` in 1 — hold PC and stack this cycle.
- `reljump_en` in 1 — relative jump: PC + signed `target`.
- `absjump_en` in 1 — absolute jump: PC = `target`.
- `call_en` in 1 — push PC+1, PC = `target`.
- `ret_en` in 1 — pop stack into PC.
- `cond_sel` in 2 — jump qualifier: 00 always, 01 `zero_q`, 10 `pari_q`, 11 `sc_q`.
- `zero_q`, `pari_q`, `sc_q` in 1 each — registered ALU flags.
- `target` in D — jump/call target or signed offset.
- `prog_ctr` out D — current instruction address.
- `running` out 1 — high in RUN.
- `done` out 1 — high in DONE.
- `stack_err` out 1 — sticky overflow/underflow flag.

## Operation
States are IDLE, RUN and DONE. `running` = (state==RUN) and `done` = (state==DONE); both are decoded from the registered state.

Reset values:
- state IDLE, `prog_ctr`=0, stack pointer `sp`=0
- `stack_err`=0, `running`=0, `done`=0
- stack contents don't-care

State transitions:
- IDLE: `req`=1 → RUN, `prog_ctr`←0, `sp`←0, `stack_err`←0. All other inputs are ignored.
- RUN with `prog_ctr`==`DONE_ADDR` → DONE. PC holds and all jump, stall and stack inputs are ignored that cycle.
- RUN with `stall`=1 → no change to PC, `sp`, stack or `stack_err`.
- RUN otherwise → next PC chosen by the priority below.
- DONE: PC holds. `req`=0 → IDLE; `done` stays high while `req` stays high.

Next-PC priority in RUN (first match wins; `cond` = flag selected by `cond_sel`):
1. `ret_en`:
   - `sp`>0: PC ← stack[`sp`-1], `sp`←`sp`-1.
   - `sp`==0 (underflow): `stack_err`←1, PC ← PC+1.
2. `call_en`:
   - `sp`<S: stack[`sp`] ← PC+1, `sp`←`sp`+1, PC ← `target`.
   - `sp`==S (overflow): `stack_err`←1, no push, PC ← PC+1.
3. `absjump_en` && `cond`: PC ← `target`.
4. `reljump_en` && `cond`: PC ← PC + `target`, where `target` is read as D-bit two's complement and the sum is modulo 2^D.
5. Otherwise PC ← PC+1, modulo 2^D (2^D−1 wraps to 0).

Further rules:
- `call_en`/`ret_en` are unconditional; `cond_sel` affects only abs/rel jumps.
- A failed conditional jump falls through to step 5 (lower-priority jumps are not evaluated).
- `stack_err` is sticky. It is cleared only by reset or by IDLE→RUN.
- Stack pointer width is clog2(S+1) bits.

## Timing
- Every state change is registered. The inputs sampled at rising edge n determine `prog_ctr`, `sp`, state and flags after edge n.
- Start latency: `req` sampled high in IDLE at edge n → `running`=1 and `prog_ctr`=0 after edge n. First instruction address is valid in cycle n+1.
- Termination: `prog_ctr`==`DONE_ADDR` in RUN at edge n → `done`=1 after edge n, with `prog_ctr` still =`DONE_ADDR`.
- Release: `req` low in DONE at edge n → `done`=0 after edge n (IDLE). A new start needs `req` sampled high at a later edge.
- Jumps, calls and returns take effect in one cycle; there are no delay slots.
- `reset` asserted at any time (mid-RUN, mid-stall, in DONE) forces reset values asynchronously. On deassertion, operation resumes from IDLE at the next edge.
- Flags are used exactly as presented at the edge; the block does not re-register them.

## Test plan
- Reset/start: assert `reset`, then release it with `req`=1 → IDLE for one edge, then `running`=1, `prog_ctr` counts 0,1,2…; at 128 `done`=1 and PC holds 128. Drop `req` → `done`=0 next edge.
- Conditional jumps: at PC=5, `reljump_en`=1, `target`=0xFFD (−3), `cond_sel`=01, `zero_q`=1 → PC=2. Same with `zero_q`=0 → PC=6. At PC=10, `absjump_en`=1, `target`=40, `cond_sel`=00 → PC=40.
- Call/return nesting with S=4: four nested calls from PCs 3, 20, 30, 40 to 20, 30, 40, 50 → four `ret_en` pulses return PC 41, 31, 21, 4. A fifth call at full depth → `stack_err`=1, PC increments.
- Underflow/priority: `ret_en` at `sp`=0 → `stack_err`=1, PC+1. `ret_en` and `call_en` together with `sp`=1 → return taken, no push.
- Stall and wrap: D=4, DONE_ADDR=15 unreachable via rel jump; `stall`=1 for 3 cycles → PC and `sp` unchanged. Rel jump from PC=14 with `target`=3 → PC=1.
- Async reset mid-run: pulse `reset` between edges at PC=57 with `sp`=2 → `prog_ctr`=0, `sp`=0, `running`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for the fetch path: req/done start handshake,
// flag-qualified jumps, a call/return stack and a stall input.
module fetch_sequencer #(
    parameter int D         = 12,
    parameter int S         = 4,
    parameter int DONE_ADDR = 128
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    input  logic                     stall,
    input  logic                     reljump_en,
    input  logic                     absjump_en,
    input  logic                     call_en,
    input  logic                     ret_en,
    input  logic [1:0]               cond_sel,
    input  logic                     zero_q,
    input  logic                     pari_q,
    input  logic                     sc_q,
    input  logic [D-1:0]             target,
    output logic [D-1:0]             prog_ctr,
    output logic                     running,
    output logic                     done,
    output logic                     stack_err,
    output logic [1:0]               dbg_state,
    output logic [$clog2(S+1)-1:0]   dbg_sp
);

    localparam int SPW = $clog2(S + 1);
    localparam int IW  = (S > 1) ? $clog2(S) : 1;
    localparam logic [D-1:0]   DONE_PC = D'(DONE_ADDR);
    localparam logic [SPW-1:0] SP_FULL = SPW'(S);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [D-1:0]     pc_q, pc_d;
    logic [SPW-1:0]   sp_q, sp_d;
    logic             err_q, err_d;
    logic [D-1:0]     stack_q [S];

    logic             push_en;
    logic [D-1:0]     pc_inc;
    logic [SPW-1:0]   sp_dec;
    logic [IW-1:0]    push_idx;
    logic [IW-1:0]    pop_idx;
    logic             cond;

    assign pc_inc   = pc_q + D'(1);
    assign sp_dec   = sp_q - SPW'(1);
    assign push_idx = sp_q[IW-1:0];
    assign pop_idx  = sp_dec[IW-1:0];

    always_comb begin
        cond = 1'b1;
        case (cond_sel)
            2'b00:   cond = 1'b1;
            2'b01:   cond = zero_q;
            2'b10:   cond = pari_q;
            default: cond = sc_q;
        endcase
    end

    // Handshake: req is a level. IDLE waits for req=1 to start; DONE holds
    // done=1 for as long as req stays high and returns to IDLE once it drops.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        err_d   = err_q;
        push_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                    sp_d    = '0;
                    err_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (pc_q == DONE_PC) begin
                    state_d = ST_DONE;
                end else if (!stall) begin
                    if (ret_en) begin
                        if (sp_q != '0) begin
                            pc_d = stack_q[pop_idx];
                            sp_d = sp_dec;
                        end else begin
                            err_d = 1'b1;
                            pc_d  = pc_inc;
                        end
                    end else if (call_en) begin
                        if (sp_q != SP_FULL) begin
                            push_en = 1'b1;
                            sp_d    = sp_q + SPW'(1);
                            pc_d    = target;
                        end else begin
                            err_d = 1'b1;
                            pc_d  = pc_inc;
                        end
                    end else if (absjump_en && cond) begin
                        pc_d = target;
                    end else if (reljump_en && cond) begin
                        // Two's-complement offset: plain modular add does the sign handling.
                        pc_d = pc_q + target;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            ST_DONE: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            sp_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
        end
    end

    // Stack contents are don't-care after reset, so they carry no reset term.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign prog_ctr  = pc_q;
    assign running   = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign stack_err = err_q;
    assign dbg_state = state_q;
    assign dbg_sp    = sp_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomised and directed bench for fetch_sequencer against a queue-based
// behavioural model of the sequencing rules.
module tb_fetch_sequencer;

    localparam int D         = 12;
    localparam int S         = 4;
    localparam int DONE_ADDR = 128;
    localparam int MOD       = 1 << D;
    localparam int SPW       = $clog2(S + 1);

    logic           clk = 1'b0;
    logic           reset;
    logic           req;
    logic           stall;
    logic           reljump_en;
    logic           absjump_en;
    logic           call_en;
    logic           ret_en;
    logic [1:0]     cond_sel;
    logic           zero_q;
    logic           pari_q;
    logic           sc_q;
    logic [D-1:0]   target;
    logic [D-1:0]   prog_ctr;
    logic           running;
    logic           done;
    logic           stack_err;
    logic [1:0]     dbg_state;
    logic [SPW-1:0] dbg_sp;

    // clock / reset
    always #5 clk = ~clk;

    fetch_sequencer #(.D(D), .S(S), .DONE_ADDR(DONE_ADDR)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .stall      (stall),
        .reljump_en (reljump_en),
        .absjump_en (absjump_en),
        .call_en    (call_en),
        .ret_en     (ret_en),
        .cond_sel   (cond_sel),
        .zero_q     (zero_q),
        .pari_q     (pari_q),
        .sc_q       (sc_q),
        .target     (target),
        .prog_ctr   (prog_ctr),
        .running    (running),
        .done       (done),
        .stack_err  (stack_err),
        .dbg_state  (dbg_state),
        .dbg_sp     (dbg_sp)
    );

    int n_checks = 0;
    int n_errors = 0;

    // scoreboard: expected prog_ctr per edge
    logic [D-1:0] exp_q[$];

    // reference model: 0 idle, 1 run, 2 done
    int m_state;
    int m_pc;
    int m_stack[$];
    bit m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit cond_now();
        case (cond_sel)
            2'd0:    return 1'b1;
            2'd1:    return zero_q;
            2'd2:    return pari_q;
            default: return sc_q;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_pc    = 0;
        m_stack.delete();
        m_err   = 1'b0;
    endtask

    task automatic model_step();
        int off;
        case (m_state)
            0: if (req) begin
                m_state = 1;
                m_pc    = 0;
                m_stack.delete();
                m_err   = 1'b0;
            end
            1: begin
                if (m_pc == DONE_ADDR) begin
                    m_state = 2;
                end else if (!stall) begin
                    if (ret_en) begin
                        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                        else begin m_err = 1'b1; m_pc = (m_pc + 1) % MOD; end
                    end else if (call_en) begin
                        if (m_stack.size() < S) begin
                            m_stack.push_back((m_pc + 1) % MOD);
                            m_pc = int'(target);
                        end else begin
                            m_err = 1'b1;
                            m_pc  = (m_pc + 1) % MOD;
                        end
                    end else if (absjump_en && cond_now()) begin
                        m_pc = int'(target);
                    end else if (reljump_en && cond_now()) begin
                        off = int'(target);
                        if (off >= MOD / 2) off = off - MOD;
                        m_pc = ((m_pc + off) % MOD + MOD) % MOD;
                    end else begin
                        m_pc = (m_pc + 1) % MOD;
                    end
                end
            end
            default: if (!req) m_state = 0;
        endcase
        exp_q.push_back(D'(m_pc));
    endtask

    task automatic compare_outputs(input string tag);
        logic [D-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_pc"}, 32'(prog_ctr), 32'(e));
        end
        check({tag, "_running"}, 32'(running), 32'(m_state == 1));
        check({tag, "_done"}, 32'(done), 32'(m_state == 2));
        check({tag, "_stack_err"}, 32'(stack_err), 32'(m_err));
        check({tag, "_sp"}, 32'(dbg_sp), 32'(m_stack.size()));
    endtask

    // driver tasks
    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_outputs(tag);
    endtask

    task automatic clear_ctl();
        stall      = 1'b0;
        reljump_en = 1'b0;
        absjump_en = 1'b0;
        call_en    = 1'b0;
        ret_en     = 1'b0;
        cond_sel   = 2'd0;
        target     = '0;
    endtask

    task automatic drive(input string tag, input bit rel, input bit abs_j, input bit cl,
                         input bit rt, input bit st, input logic [1:0] cs, input int tgt);
        reljump_en = rel;
        absjump_en = abs_j;
        call_en    = cl;
        ret_en     = rt;
        stall      = st;
        cond_sel   = cs;
        target     = D'(tgt);
        step(tag);
        clear_ctl();
    endtask

    task automatic run_to(input int pc);
        int n = 0;
        while (m_pc != pc && n < 300) begin
            step("count");
            n++;
        end
        check("run_to_pc", 32'(prog_ctr), 32'(pc));
    endtask

    task automatic async_reset_pulse(input string tag);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check({tag, "_async_pc"}, 32'(prog_ctr), 32'd0);
        check({tag, "_async_running"}, 32'(running), 32'd0);
        check({tag, "_async_done"}, 32'(done), 32'd0);
        check({tag, "_async_sp"}, 32'(dbg_sp), 32'd0);
        check({tag, "_async_err"}, 32'(stack_err), 32'd0);
        #1 reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        reset  = 1'b1;
        req    = 1'b0;
        zero_q = 1'b0;
        pari_q = 1'b0;
        sc_q   = 1'b0;
        clear_ctl();
        model_reset();
        #12;
        check("reset_pc", 32'(prog_ctr), 32'd0);
        check("reset_running", 32'(running), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(stack_err), 32'd0);
        check("reset_sp", 32'(dbg_sp), 32'd0);

        @(negedge clk);
        reset = 1'b0;
        req   = 1'b1;
        step("start");
        step("count");
        step("count");

        // conditional jumps
        run_to(5);
        zero_q = 1'b1;
        drive("rel_taken", 1, 0, 0, 0, 0, 2'b01, 'hFFD);
        check("rel_taken_pc2", 32'(prog_ctr), 32'd2);
        run_to(5);
        zero_q = 1'b0;
        drive("rel_nottaken", 1, 0, 0, 0, 0, 2'b01, 'hFFD);
        check("rel_nottaken_pc6", 32'(prog_ctr), 32'd6);
        run_to(10);
        drive("abs", 0, 1, 0, 0, 0, 2'b00, 40);
        check("abs_pc40", 32'(prog_ctr), 32'd40);

        // nested calls, overflow, returns
        drive("abs3", 0, 1, 0, 0, 0, 2'b00, 3);
        drive("call1", 0, 0, 1, 0, 0, 2'b00, 20);
        drive("call2", 0, 0, 1, 0, 0, 2'b00, 30);
        drive("call3", 0, 0, 1, 0, 0, 2'b00, 40);
        drive("call4", 0, 0, 1, 0, 0, 2'b00, 50);
        drive("call_ovf", 0, 0, 1, 0, 0, 2'b00, 60);
        check("ovf_pc51", 32'(prog_ctr), 32'd51);
        drive("ret1", 0, 0, 0, 1, 0, 2'b00, 0);
        check("ret1_pc41", 32'(prog_ctr), 32'd41);
        drive("ret2", 0, 0, 0, 1, 0, 2'b00, 0);
        drive("ret3", 0, 0, 0, 1, 0, 2'b00, 0);
        drive("ret4", 0, 0, 0, 1, 0, 2'b00, 0);
        check("ret4_pc4", 32'(prog_ctr), 32'd4);
        drive("ret_unf", 0, 0, 0, 1, 0, 2'b00, 0);
        drive("call100", 0, 0, 1, 0, 0, 2'b00, 100);
        drive("ret_call", 0, 0, 1, 1, 0, 2'b00, 77);
        check("ret_call_pc6", 32'(prog_ctr), 32'd6);

        // stall
        drive("call60", 0, 0, 1, 0, 0, 2'b00, 60);
        for (int i = 0; i < 3; i++) drive("stall", 1, 1, 1, 1, 1, 2'b00, 9);
        drive("ret_after_stall", 0, 0, 0, 1, 0, 2'b00, 0);

        // wrap
        drive("abs4094", 0, 1, 0, 0, 0, 2'b00, 4094);
        drive("rel_wrap", 1, 0, 0, 0, 0, 2'b00, 3);
        check("rel_wrap_pc1", 32'(prog_ctr), 32'd1);
        drive("abs4095", 0, 1, 0, 0, 0, 2'b00, 4095);
        step("inc_wrap");

        // async reset mid-run at PC 57 with two entries pushed
        drive("abs50", 0, 1, 0, 0, 0, 2'b00, 50);
        drive("call55", 0, 0, 1, 0, 0, 2'b00, 55);
        drive("call57", 0, 0, 1, 0, 0, 2'b00, 57);
        async_reset_pulse("midrun");
        step("restart");

        // termination and release
        drive("abs125", 0, 1, 0, 0, 0, 2'b00, 125);
        run_to(DONE_ADDR);
        drive("enter_done", 1, 1, 1, 1, 0, 2'b00, 3);
        step("hold_done");
        req = 1'b0;
        step("release");
        step("idle");
        req = 1'b1;
        step("restart2");

        // random phase
        for (int c = 0; c < 4000; c++) begin
            req        = ($urandom_range(0, 15) != 0);
            stall      = ($urandom_range(0, 7) == 0);
            reljump_en = ($urandom_range(0, 9) == 0);
            absjump_en = ($urandom_range(0, 11) == 0);
            call_en    = ($urandom_range(0, 13) == 0);
            ret_en     = ($urandom_range(0, 13) == 0);
            cond_sel   = 2'($urandom_range(0, 3));
            zero_q     = 1'($urandom_range(0, 1));
            pari_q     = 1'($urandom_range(0, 1));
            sc_q       = 1'($urandom_range(0, 1));
            r          = int'($urandom_range(0, 9));
            if (r < 4)      target = D'(int'($urandom_range(0, 16)) - 8);
            else if (r < 5) target = D'(DONE_ADDR);
            else            target = D'($urandom_range(0, 200));
            step("rand");
            if ($urandom_range(0, 499) == 0) async_reset_pulse("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
